// File: rtl/instruction_fetch_queue.sv
// Purpose     : sequential instruction prefetch into a DEPTH-entry queue, one outstanding req/ack fetch.
// Latency     : fetch_ack at cycle t -> entry visible on issue_valid at t+1 (no bypass).
// Backpressure: requests are issued only when a slot is free (counting this cycle's pop); decode stalls via issue_ready.
//
// Ports
//   clock, reset                 rising-edge clock, asynchronous active-low reset
//   fetch_req/fetch_pc           request to memory, held (address stable) until fetch_ack
//   fetch_ack/fetch_data         memory response, data valid with ack
//   redirect/redirect_pc         flush queue and restart fetching at redirect_pc
//   issue_valid/issue_ready      head-entry handshake towards decode
//   issue_instruction/issue_pc   head entry (NOP when queue is empty)
//   occupancy                    number of valid entries, 0..DEPTH
module instruction_fetch_queue #(
   parameter int               XLEN     = 32,
   parameter int               DEPTH    = 4,
   parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0]  NOP      = 32'h0000_0013
) (
   input  logic                      clock,
   input  logic                      reset,
   output logic                      fetch_req,
   output logic [XLEN-1:0]           fetch_pc,
   input  logic                      fetch_ack,
   input  logic [XLEN-1:0]           fetch_data,
   input  logic                      redirect,
   input  logic [XLEN-1:0]           redirect_pc,
   input  logic                      issue_ready,
   output logic                      issue_valid,
   output logic [XLEN-1:0]           issue_instruction,
   output logic [XLEN-1:0]           issue_pc,
   output logic [$clog2(DEPTH):0]    occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [CW-1:0]     count;
   logic [CW-1:0]     count_after;
   logic [XLEN-1:0]   pending_pc;
   logic [XLEN-1:0]   pending_pc_nxt;
   logic [XLEN-1:0]   fetch_pc_nxt;

   logic [XLEN-1:0]   instr_mem [DEPTH];
   logic [XLEN-1:0]   pc_mem    [DEPTH];

   logic              has_entry;
   logic              push;
   logic              pop;
   logic              space_after;

   // ---------------------------------------------------------------
   // Queue control
   // ---------------------------------------------------------------
   assign has_entry   = (count != '0);
   // A redirect cycle hides the head so decode can never pop a stale entry.
   assign issue_valid = has_entry & ~redirect;
   assign pop         = issue_valid & issue_ready;
   // Responses only land in REQ; a redirect in the same cycle drops them.
   assign push        = (state == REQ) & fetch_ack & ~redirect;
   assign count_after = count + CW'(push) - CW'(pop);
   // Space test includes this cycle's push and pop, so a request is only
   // ever launched when its response is guaranteed a slot.
   assign space_after = (count_after < CW'(DEPTH));

   assign fetch_req         = (state != IDLE);
   assign occupancy         = count;
   assign issue_instruction = has_entry ? instr_mem[head] : NOP;
   assign issue_pc          = has_entry ? pc_mem[head]    : fetch_pc;

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next state and fetch address
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt      = state;
      fetch_pc_nxt   = fetch_pc;
      pending_pc_nxt = pending_pc;
      case (state)
         IDLE: begin
            if (redirect) begin
               state_nxt    = REQ;
               fetch_pc_nxt = redirect_pc;
            end else if (space_after) begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (redirect) begin
               if (fetch_ack) begin
                  // Response arrived with the redirect: drop it and restart now.
                  state_nxt    = REQ;
                  fetch_pc_nxt = redirect_pc;
               end else begin
                  // Request is still on the bus and cannot be withdrawn; keep the
                  // old address visible and remember where to go afterwards.
                  state_nxt      = DISCARD;
                  pending_pc_nxt = redirect_pc;
               end
            end else if (fetch_ack) begin
               fetch_pc_nxt = fetch_pc + XLEN'(4);
               state_nxt    = space_after ? REQ : IDLE;
            end
         end
         DISCARD: begin
            if (fetch_ack) begin
               // The in-flight response is swallowed; a redirect arriving in
               // this very cycle supersedes the remembered target.
               state_nxt    = REQ;
               fetch_pc_nxt = redirect ? redirect_pc : pending_pc;
            end else if (redirect) begin
               pending_pc_nxt = redirect_pc;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath registers: address, pointers, occupancy
   // ---------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc   <= RESET_PC;
         pending_pc <= RESET_PC;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
      end else begin
         fetch_pc   <= fetch_pc_nxt;
         pending_pc <= pending_pc_nxt;
         if (redirect) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            // DEPTH is a power of two, so pointer wrap is the natural overflow.
            if (push) begin
               tail <= tail + PW'(1);
            end
            if (pop) begin
               head <= head + PW'(1);
            end
            count <= count_after;
         end
      end
   end

   // Storage needs no reset: occupancy gates every read.
   always_ff @(posedge clock) begin
      if (push) begin
         instr_mem[tail] <= fetch_data;
         pc_mem[tail]    <= fetch_pc;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
module tb_instruction_fetch_queue;

   localparam logic [31:0] NOP_W = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetch_ack;
   logic [31:0] fetch_data;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        issue_ready;

   logic        a_req, a_valid;
   logic [31:0] a_pc, a_instr, a_ipc;
   logic [2:0]  a_occ;
   logic        b_req, b_valid;
   logic [31:0] b_pc, b_instr, b_ipc;
   logic [2:0]  b_occ;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   instruction_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000), .NOP(NOP_W)) dut_a (
      .clock(clock), .reset(reset),
      .fetch_req(a_req), .fetch_pc(a_pc), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .issue_ready(issue_ready), .issue_valid(a_valid),
      .issue_instruction(a_instr), .issue_pc(a_ipc), .occupancy(a_occ)
   );

   instruction_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC), .NOP(NOP_W)) dut_b (
      .clock(clock), .reset(reset),
      .fetch_req(b_req), .fetch_pc(b_pc), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .issue_ready(issue_ready), .issue_valid(b_valid),
      .issue_instruction(b_instr), .issue_pc(b_ipc), .occupancy(b_occ)
   );

   typedef struct {
      logic        ack;
      logic [31:0] data;
      logic        ready;
      logic        e_req;
      logic [31:0] e_pc;
      logic        e_valid;
      logic [31:0] e_ipc;
      logic [31:0] e_instr;
      logic [2:0]  e_occ;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } sb_t;

   localparam int NV = 13;
   vec_t vecs [NV];
   sb_t  sb [$];

   function automatic logic [31:0] dat(input logic [31:0] pc);
      return 32'hC0DE_0000 ^ pc;
   endfunction

   function automatic vec_t mk(input logic ack, input logic [31:0] data, input logic ready,
                               input logic e_req, input logic [31:0] e_pc, input logic e_valid,
                               input logic [31:0] e_ipc, input logic [31:0] e_instr, input logic [2:0] e_occ);
      vec_t v;
      v.ack = ack; v.data = data; v.ready = ready;
      v.e_req = e_req; v.e_pc = e_pc; v.e_valid = e_valid;
      v.e_ipc = e_ipc; v.e_instr = e_instr; v.e_occ = e_occ;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Leaves the bench at the falling edge on which reset is released.
   task automatic do_reset();
      fetch_ack = 1'b0; fetch_data = '0; redirect = 1'b0; redirect_pc = '0; issue_ready = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic drive(input logic ack, input logic [31:0] data, input logic rdy,
                        input logic rd, input logic [31:0] rpc);
      fetch_ack = ack; fetch_data = data; issue_ready = rdy; redirect = rd; redirect_pc = rpc;
      #1;
   endtask

   task automatic next_cyc();
      @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          pops;
      int          nacc;
      logic [31:0] exp_pc;
      logic        req_now;
      sb_t         e;

      // Ack every cycle with decode stalled (fill), then single pops and a refill,
      // then a simultaneous push and pop.
      vecs[0]  = mk(1, 32'hDEAD_BEEF,  0, 0, 32'h00, 0, 32'h0, NOP_W,        3'd0);
      vecs[1]  = mk(1, dat(32'h00),    0, 1, 32'h00, 0, 32'h0, NOP_W,        3'd0);
      vecs[2]  = mk(1, dat(32'h04),    0, 1, 32'h04, 1, 32'h0, dat(32'h00),  3'd1);
      vecs[3]  = mk(1, dat(32'h08),    0, 1, 32'h08, 1, 32'h0, dat(32'h00),  3'd2);
      vecs[4]  = mk(1, dat(32'h0C),    0, 1, 32'h0C, 1, 32'h0, dat(32'h00),  3'd3);
      vecs[5]  = mk(1, 32'hDEAD_BEEF,  0, 0, 32'h10, 1, 32'h0, dat(32'h00),  3'd4);
      vecs[6]  = mk(1, 32'hDEAD_BEEF,  0, 0, 32'h10, 1, 32'h0, dat(32'h00),  3'd4);
      vecs[7]  = mk(0, 32'h0,          1, 0, 32'h10, 1, 32'h0, dat(32'h00),  3'd4);
      vecs[8]  = mk(0, 32'h0,          0, 1, 32'h10, 1, 32'h4, dat(32'h04),  3'd3);
      vecs[9]  = mk(1, dat(32'h10),    0, 1, 32'h10, 1, 32'h4, dat(32'h04),  3'd3);
      vecs[10] = mk(0, 32'h0,          1, 0, 32'h14, 1, 32'h4, dat(32'h04),  3'd4);
      vecs[11] = mk(1, dat(32'h14),    1, 1, 32'h14, 1, 32'h8, dat(32'h08),  3'd3);
      vecs[12] = mk(0, 32'h0,          0, 1, 32'h18, 1, 32'hC, dat(32'h0C),  3'd3);

      // Reset state while reset is held low.
      fetch_ack = 1'b0; fetch_data = '0; redirect = 1'b0; redirect_pc = '0; issue_ready = 1'b0;
      reset = 1'b0;
      @(negedge clock); #1;
      check("rst_req",   32'(a_req),   32'd0);
      check("rst_pc",    a_pc,         32'h0);
      check("rst_valid", 32'(a_valid), 32'd0);
      check("rst_instr", a_instr,      NOP_W);
      check("rst_ipc",   a_ipc,        32'h0);
      check("rst_occ",   32'(a_occ),   32'd0);
      check("rst_b_pc",  b_pc,         32'hFFFF_FFFC);
      check("rst_b_ipc", b_ipc,        32'hFFFF_FFFC);

      // Table-driven fill / drain vectors.
      do_reset();
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].ack, vecs[i].data, vecs[i].ready, 1'b0, 32'h0);
         check($sformatf("v%0d_req", i),   32'(a_req),   32'(vecs[i].e_req));
         check($sformatf("v%0d_pc", i),    a_pc,         vecs[i].e_pc);
         check($sformatf("v%0d_valid", i), 32'(a_valid), 32'(vecs[i].e_valid));
         check($sformatf("v%0d_occ", i),   32'(a_occ),   32'(vecs[i].e_occ));
         check($sformatf("v%0d_instr", i), a_instr,      vecs[i].e_instr);
         if (vecs[i].e_valid)
            check($sformatf("v%0d_ipc", i), a_ipc, vecs[i].e_ipc);
         next_cyc();
      end

      // Redirect while a request is outstanding: DISCARD, then restart.
      do_reset();
      drive(0, 32'h0, 0, 0, 32'h0);            next_cyc();
      drive(1, dat(32'h0), 0, 0, 32'h0);       next_cyc();
      drive(1, dat(32'h4), 0, 0, 32'h0);       next_cyc();
      drive(0, 32'h0, 0, 1, 32'h100);
      check("t3_req",       32'(a_req),   32'd1);
      check("t3_pc",        a_pc,         32'h8);
      check("t3_redir_vld", 32'(a_valid), 32'd0);
      check("t3_occ_pre",   32'(a_occ),   32'd2);
      next_cyc();
      drive(0, 32'h0, 0, 0, 32'h0);
      check("t3_disc_req",  32'(a_req),   32'd1);
      check("t3_disc_pc",   a_pc,         32'h8);
      check("t3_disc_occ",  32'(a_occ),   32'd0);
      check("t3_disc_vld",  32'(a_valid), 32'd0);
      check("t3_disc_nop",  a_instr,      NOP_W);
      next_cyc();
      drive(1, 32'hBAD0_0008, 0, 0, 32'h0);
      check("t3_oldack_pc", a_pc,         32'h8);
      next_cyc();
      drive(0, 32'h0, 0, 0, 32'h0);
      check("t3_new_req",   32'(a_req),   32'd1);
      check("t3_new_pc",    a_pc,         32'h100);
      check("t3_dropped",   32'(a_occ),   32'd0);
      next_cyc();
      drive(1, dat(32'h100), 0, 0, 32'h0);     next_cyc();

      // Redirect with same-cycle ack and issue_ready.
      drive(0, 32'h0, 0, 0, 32'h0);
      check("t3_first_vld", 32'(a_valid), 32'd1);
      check("t3_first_ipc", a_ipc,        32'h100);
      check("t3_first_ins", a_instr,      dat(32'h100));
      check("t4_pc_pre",    a_pc,         32'h104);
      drive(1, 32'hBAD0_0104, 1, 1, 32'h200);
      check("t4_valid",     32'(a_valid), 32'd0);
      next_cyc();
      drive(1, dat(32'h200), 0, 0, 32'h0);
      check("t4_occ",       32'(a_occ),   32'd0);
      check("t4_req",       32'(a_req),   32'd1);
      check("t4_pc",        a_pc,         32'h200);
      check("t4_nop",       a_instr,      NOP_W);
      next_cyc();
      drive(0, 32'h0, 0, 0, 32'h0);
      check("t4_occ_after", 32'(a_occ),   32'd1);
      check("t4_ipc_after", a_ipc,        32'h200);
      check("t4_pc_after",  a_pc,         32'h204);
      next_cyc();

      // Reset mid-request with an ack pending.
      drive(1, 32'hBAD0_0204, 0, 0, 32'h0);
      check("t6_pre_req",   32'(a_req),   32'd1);
      reset = 1'b0;
      #1;
      check("t6_req",       32'(a_req),   32'd0);
      check("t6_pc",        a_pc,         32'h0);
      check("t6_valid",     32'(a_valid), 32'd0);
      check("t6_occ",       32'(a_occ),   32'd0);
      check("t6_instr",     a_instr,      NOP_W);
      check("t6_ipc",       a_ipc,        32'h0);
      next_cyc(); #1;
      check("t6_hold_occ",  32'(a_occ),   32'd0);
      check("t6_hold_req",  32'(a_req),   32'd0);
      reset = 1'b1;
      drive(0, 32'h0, 0, 0, 32'h0);
      check("t6_rel_req",   32'(a_req),   32'd0);
      next_cyc();
      drive(0, 32'h0, 0, 0, 32'h0);
      check("t6_first_req", 32'(a_req),   32'd1);
      check("t6_first_pc",  a_pc,         32'h0);
      check("t6_empty_nop", a_instr,      NOP_W);
      check("t6_empty_vld", 32'(a_valid), 32'd0);
      next_cyc();

      // Address wrap and pointer wrap on dut_b with a memory model and scoreboard.
      do_reset();
      exp_pc = 32'hFFFF_FFFC;
      nacc   = 0;
      pops   = 0;
      for (int i = 0; i < 60; i++) begin
         req_now = b_req;
         drive(req_now && ($urandom_range(0, 3) != 0), dat(exp_pc),
               (i < 12) ? 1'b0 : ((i < 20) ? 1'b1 : 1'($urandom_range(0, 1))), 1'b0, 32'h0);
         check("sb_occ",   32'(b_occ),   32'(sb.size()));
         check("sb_valid", 32'(b_valid), 32'(sb.size() != 0));
         if (b_valid && issue_ready) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_pop", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check("sb_ipc",   b_ipc,   e.pc);
               check("sb_instr", b_instr, e.instr);
               pops++;
            end
         end
         if (fetch_ack) begin
            check("sb_fetch_pc", b_pc, exp_pc);
            if (nacc == 1)
               check("t5_second_pc", b_pc, 32'h0);
            e.pc = exp_pc; e.instr = dat(exp_pc);
            sb.push_back(e);
            exp_pc = exp_pc + 32'd4;
            nacc++;
         end
         next_cyc();
      end
      for (int i = 0; i < 20 && sb.size() != 0; i++) begin
         drive(0, 32'h0, 1, 0, 32'h0);
         check("drain_occ", 32'(b_occ), 32'(sb.size()));
         if (b_valid) begin
            e = sb.pop_front();
            check("drain_ipc",   b_ipc,   e.pc);
            check("drain_instr", b_instr, e.instr);
            pops++;
         end
         next_cyc();
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
      check("wrap_pops",   32'(pops >= 8), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
